// File: rtl/prbs_randomizer_par.sv
// Parallel PRBS randomizer (1 + x^14 + x^15), W bits per word, MSB first, with a
// one-word registered output stage and a per-block reload from the working seed.
module prbs_randomizer_par #(
  parameter int W          = 1,
  parameter int BLOCK_BITS = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:15]  seed,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  localparam int WORDS = BLOCK_BITS / W;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  if (!((W == 1) || (W == 2) || (W == 4) || (W == 8)) || ((BLOCK_BITS % W) != 0)
      || (BLOCK_BITS < W)) begin : g_bad_param
    $error("prbs_randomizer_par: W must be 1/2/4/8 and divide BLOCK_BITS");
  end

  // W serial LFSR steps unrolled; in_data[W-1] is the earliest bit in time.
  function automatic void scramble(input  logic [1:15]  s_i,
                                   input  logic [W-1:0] d_i,
                                   output logic [1:15]  s_o,
                                   output logic [W-1:0] d_o);
    logic [1:15] st;
    logic        k;
    st  = s_i;
    d_o = d_i;
    for (int i = W - 1; i >= 0; i--) begin
      k      = st[14] ^ st[15];
      d_o[i] = d_i[i] ^ k;
      st     = {k, st[1:14]};
    end
    s_o = st;
  endfunction

  logic [1:15]   seed_q, seed_d;
  logic [1:15]   lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          fire;
  logic [1:15]   start_lfsr;
  logic [1:15]   blk_seed;
  logic [CW-1:0] start_cnt;
  logic [1:15]   step_lfsr;
  logic [W-1:0]  step_data;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    fire        = in_valid && in_ready;
    // A load takes effect before a coincident fire, so that word is count 0 of the new seed.
    start_lfsr  = load ? seed : lfsr_q;
    blk_seed    = load ? seed : seed_q;
    start_cnt   = load ? {CW{1'b0}} : cnt_q;
    scramble(start_lfsr, in_data, step_lfsr, step_data);
    seed_d = blk_seed;
    if (fire) begin
      out_valid_d = 1'b1;
      out_last_d  = (start_cnt == LAST_CNT);
      out_data_d  = en ? step_data : in_data;
      if (start_cnt == LAST_CNT) begin
        cnt_d  = {CW{1'b0}};
        lfsr_d = blk_seed;
      end else begin
        cnt_d  = start_cnt + CW'(1);
        lfsr_d = en ? step_lfsr : start_lfsr;
      end
    end else begin
      cnt_d  = start_cnt;
      lfsr_d = start_lfsr;
      if (out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q      <= 15'd0;
      lfsr_q      <= 15'd0;
      cnt_q       <= {CW{1'b0}};
      out_data_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
